// File: rtl/feature_window_reader.sv
// feature_window_reader: raster-scans a feature map, fetching one KxK window pixel by pixel and handing it out.
module feature_window_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int FMAP_W     = 32,
  parameter int FMAP_H     = 32,
  parameter int K          = 3
) (
  input  logic                         iclk,
  input  logic                         irst,
  input  logic                         istart,
  output logic                         obusy,
  output logic                         odone,
  output logic                         mem_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_valid,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [K*K*DATA_WIDTH-1:0]    win_data,
  output logic                         win_last
);
  localparam int RN = FMAP_H - K + 1;
  localparam int CN = FMAP_W - K + 1;
  localparam int RW = RN > 1 ? $clog2(RN) : 1;
  localparam int CW = CN > 1 ? $clog2(CN) : 1;
  localparam int KW = K > 1 ? $clog2(K) : 1;
  localparam logic [RW-1:0] RMAX = RW'(RN - 1);
  localparam logic [CW-1:0] CMAX = CW'(CN - 1);
  localparam logic [KW-1:0] KMAX = KW'(K - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [RW-1:0]               r_q, r_d;
  logic [CW-1:0]               c_q, c_d;
  logic [KW-1:0]               kx_q, kx_d, ky_q, ky_d;
  logic [K*K*DATA_WIDTH-1:0]   win_q, win_d;
  logic                        last_win, last_slot;
  int                          slot;

  always_comb begin
    last_win  = r_q == RMAX && c_q == CMAX;
    last_slot = kx_q == KMAX && ky_q == KMAX;
    slot      = int'(ky_q) * K + int'(kx_q);
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    win_d     = win_q;
    case (state_q)
      IDLE: if (istart) begin
        state_d = REQ;
        r_d     = '0;
        c_d     = '0;
        kx_d    = '0;
        ky_d    = '0;
      end
      REQ:  state_d = WAIT;
      WAIT: if (mem_valid) begin
        win_d[slot*DATA_WIDTH +: DATA_WIDTH] = mem_data;
        state_d = last_slot ? OUT : REQ;
        kx_d    = last_slot || kx_q == KMAX ? '0 : kx_q + 1'b1;
        ky_d    = !last_slot && kx_q == KMAX ? ky_q + 1'b1 : ky_q;
      end
      OUT: if (win_ready) begin
        // On the final window r holds at its limit so it never steps past the map.
        state_d = last_win ? DONE : REQ;
        kx_d    = '0;
        ky_d    = '0;
        c_d     = c_q == CMAX ? '0 : c_q + 1'b1;
        r_d     = c_q == CMAX && !last_win ? r_q + 1'b1 : r_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      win_q   <= win_d;
    end
  end

  assign obusy     = state_q != IDLE;
  assign odone     = state_q == DONE;
  assign mem_en    = state_q == REQ;
  assign mem_addr  = mem_en ? ADDR_WIDTH'((32'(r_q) + 32'(ky_q)) * 32'(FMAP_W) + 32'(c_q) + 32'(kx_q)) : '0;
  assign win_valid = state_q == OUT;
  assign win_last  = win_valid && last_win;
  assign win_data  = win_q;
endmodule

// File: tb/tb_feature_window_reader.sv
// tb_feature_window_reader: random-data scans of a 4x4 map with K=3 against a window/address reference model.
module tb_feature_window_reader;
  localparam int DW = 16, AW = 16, FW = 4, FH = 4, K = 3;
  localparam int NC = FW - K + 1, NW = (FW - K + 1) * (FH - K + 1);

  logic iclk = 0, irst = 0, istart = 0, win_ready = 0;
  logic obusy, odone, mem_en, mem_valid, win_valid, win_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [K*K*DW-1:0] win_data;

  feature_window_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FMAP_W(FW), .FMAP_H(FH), .K(K)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .obusy(obusy), .odone(odone),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .win_last(win_last)
  );

  always #5 iclk = ~iclk;

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] mem [FW*FH];
  int lat = 2;
  logic [7:0] pv;
  logic [AW-1:0] pa [8];
  logic spur = 0;
  logic [DW-1:0] spur_data = 0;

  always @(posedge iclk or negedge irst)
    if (!irst) pv <= '0;
    else begin
      pv <= {pv[6:0], mem_en};
      pa[0] <= mem_addr;
      for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end
  assign mem_valid = pv[lat-1] | spur;
  assign mem_data  = pv[lat-1] ? mem[pa[lat-1][3:0]] : spur_data;

  logic [K*K*DW-1:0] exp_win [NW];
  int exp_addr[$];
  task automatic build_model();
    logic [K*K*DW-1:0] w;
    int a;
    foreach (mem[i]) mem[i] = DW'($urandom);
    exp_addr.delete();
    for (int r = 0; r <= FH - K; r++)
      for (int c = 0; c <= FW - K; c++) begin
        w = '0;
        for (int y = 0; y < K; y++)
          for (int x = 0; x < K; x++) begin
            a = (r + y) * FW + c + x;
            exp_addr.push_back(a);
            w[(y*K+x)*DW +: DW] = mem[a];
          end
        exp_win[r*NC+c] = w;
      end
  endtask

  int cyc = 0;
  always @(posedge iclk) cyc++;

  bit mon_on = 0, lat_chk = 0, need_start = 1, prev_en = 0;
  int wi = 0, ndone = 0, win_start = 0, last_xfer = -10;
  always @(negedge iclk) if (mon_on) begin
    if (mem_en) begin
      if (exp_addr.size() == 0) check("addr_extra", 1, 0);
      else check("addr", mem_addr, exp_addr.pop_front());
      check("en_consec", prev_en, 0);
      if (need_start) begin win_start = cyc; need_start = 0; end
    end
    prev_en = mem_en;
    if (win_valid) begin
      check("en_in_out", mem_en, 0);
      if (wi >= NW) check("win_extra", 1, 0);
      else begin
        check("win", win_data, exp_win[wi]);
        check("last", win_last, wi == NW - 1);
        if (win_ready) begin
          if (lat_chk) check("lat", cyc - win_start, 27);
          if (wi == NW - 1) last_xfer = cyc;
          wi++;
          need_start = 1;
        end
      end
    end
    if (odone) begin
      ndone++;
      check("done_lat", cyc, last_xfer + 1);
    end
  end

  int mode = 0, stall = 0;
  bit kick = 0, spur_en = 0;
  initial forever begin
    @(posedge iclk); #1;
    stall = win_valid ? stall + 1 : 0;
    win_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : stall > 10;
    spur = spur_en && (!obusy || win_valid) && $urandom_range(0, 1) == 1;
    spur_data = DW'($urandom);
    if (kick) istart = obusy && $urandom_range(0, 2) == 0;
  end

  task automatic start_scan();
    build_model();
    wi = 0; ndone = 0; need_start = 1; prev_en = 0; last_xfer = -10; mon_on = 1;
    @(posedge iclk); #1 istart = 1;
    @(posedge iclk); #1 istart = 0;
  endtask

  task automatic end_scan();
    int n = 0;
    while (!odone && n < 3000) begin @(negedge iclk); n++; end
    kick = 0;
    istart = 0;
    if (n >= 3000) check("timeout", 1, 0);
    repeat (3) @(negedge iclk);
    check("nwin", wi, NW);
    check("ndone", ndone, 1);
    check("idle_after", obusy, 0);
    check("addr_left", exp_addr.size(), 0);
  endtask

  task automatic run_scan(input bit k);
    start_scan();
    kick = k;
    end_scan();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge iclk); #1;
    check("rst_busy", obusy, 0);
    check("rst_done", odone, 0);
    check("rst_en", mem_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", win_valid, 0);
    check("rst_last", win_last, 0);
    check("rst_data", win_data, 0);
    #2 irst = 1;
    spur_en = 1;
    repeat (6) begin
      @(negedge iclk);
      check("idle_busy", obusy, 0);
      check("idle_valid", win_valid, 0);
    end
    lat = 2; mode = 0; lat_chk = 1; run_scan(0); lat_chk = 0;
    lat = 3; mode = 1; run_scan(1);
    lat = 1; mode = 2; run_scan(0);
    lat = 3; mode = 0;
    start_scan();
    n = 0;
    while (!(wi == 1 && mem_en) && n < 3000) begin @(negedge iclk); n++; end
    if (n >= 3000) check("mid_timeout", 1, 0);
    @(posedge iclk); #2;
    check("mid_busy", obusy, 1);
    mon_on = 0;
    irst = 0;
    #1;
    check("mid_busy0", obusy, 0);
    check("mid_done0", odone, 0);
    check("mid_en0", mem_en, 0);
    check("mid_addr0", mem_addr, 0);
    check("mid_valid0", win_valid, 0);
    check("mid_last0", win_last, 0);
    check("mid_data0", win_data, 0);
    @(negedge iclk); irst = 1;
    repeat (3) @(negedge iclk);
    check("mid_idle", obusy, 0);
    lat = 2; mode = 1; run_scan(0);
    for (int s = 0; s < 3; s++) begin
      lat = $urandom_range(1, 4); mode = $urandom_range(0, 2); run_scan(1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
